// File: rtl/ram_burst_reader.sv
`default_nettype none
// ============================================================================
// Module   : ram_burst_reader
// Purpose  : Reads a burst of consecutive words from a single-port RAM with
//            one-cycle read latency and presents them on a ready/valid
//            stream through a 2-entry output buffer.
// Ports    : AClkH/AResetHN  - clock (rising edge), async active-low reset
//            AClkHEn         - clock enable for the control path
//            ACmd*           - burst command (start address, length, handshake)
//            ARam*           - RAM read port (write enable tied low)
//            AStrm*          - output stream (data, valid, last, ready)
//            ABusy / ADone   - burst in progress / completion pulse
// Revision : 1.0 - initial release
// ============================================================================
module ram_burst_reader #(
  parameter int CAddrLen = 13,
  parameter int CDataLen = 128,
  parameter int CLenLen  = 8
) (
  input  logic                AClkH,
  input  logic                AResetHN,
  input  logic                AClkHEn,
  input  logic [CAddrLen-1:0] ACmdAddr,
  input  logic [CLenLen-1:0]  ACmdLen,
  input  logic                ACmdValid,
  output logic                ACmdReady,
  output logic [CAddrLen-1:0] ARamAddr,
  output logic                ARamRdEn,
  output logic                ARamWrEn,
  input  logic [CDataLen-1:0] ARamMiso,
  output logic [CDataLen-1:0] AStrmData,
  output logic                AStrmValid,
  output logic                AStrmLast,
  input  logic                AStrmReady,
  output logic                ABusy,
  output logic                ADone
);

  localparam logic [CAddrLen-1:0] c_addrOne = {{(CAddrLen-1){1'b0}}, 1'b1};
  localparam logic [CLenLen-1:0]  c_lenOne  = {{(CLenLen-1){1'b0}}, 1'b1};
  localparam logic [CLenLen-1:0]  c_lenZero = '0;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t r_state;
  state_t w_stateNext;

  logic [CAddrLen-1:0] r_nextAddr;     // address of the next read to issue
  logic [CAddrLen-1:0] r_holdAddr;     // last issued address, shown when idle
  logic [CLenLen-1:0]  r_remain;       // reads still to issue
  logic                r_inFlight;     // read issued in the previous cycle
  logic                r_inFlightLast; // that read is the final burst word
  logic [1:0]          r_occ;          // output buffer occupancy (0..2)
  logic [CDataLen-1:0] r_data0;        // head entry
  logic [CDataLen-1:0] r_data1;
  logic                r_last0;
  logic                r_last1;
  logic                r_done;

  logic                w_issue;
  logic                w_issueLast;
  logic [CAddrLen-1:0] w_issueAddr;
  logic [CLenLen-1:0]  w_curRemain;
  logic                w_pop;
  logic                w_finish;
  logic                w_zeroAccept;
  logic                w_wrSlot0;
  logic [2:0]          w_level;        // occupancy after pop plus in-flight read

  // --------------------------------------------------------------------------
  // State register
  // --------------------------------------------------------------------------
  always_ff @(posedge AClkH or negedge AResetHN) begin
    if (!AResetHN) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_stateNext;
    end
  end

  // --------------------------------------------------------------------------
  // Next state, read issue and handshake decode
  // --------------------------------------------------------------------------
  always_comb begin
    w_stateNext  = r_state;
    ACmdReady    = 1'b0;
    w_issue      = 1'b0;
    w_issueAddr  = r_nextAddr;
    w_curRemain  = r_remain;
    w_finish     = 1'b0;
    w_zeroAccept = 1'b0;
    w_pop        = (r_occ != 2'd0) && AStrmReady && AClkHEn;
    w_level      = {1'b0, r_occ} - {2'b00, w_pop} + {2'b00, r_inFlight};

    case (r_state)
      IDLE: begin
        // Held low during reset and while the completion pulse is still
        // showing, so a new command starts the cycle after ADone.
        ACmdReady = AResetHN && AClkHEn && !r_done;
        if (ACmdValid && ACmdReady) begin
          if (ACmdLen == c_lenZero) begin
            w_zeroAccept = 1'b1;
          end else begin
            // The first read goes out in the accepting cycle (buffer is
            // empty, nothing in flight), giving a 2-cycle first-word latency.
            w_issue     = 1'b1;
            w_issueAddr = ACmdAddr;
            w_curRemain = ACmdLen;
            w_stateNext = (ACmdLen == c_lenOne) ? DRAIN : RUN;
          end
        end
      end
      RUN: begin
        if (AClkHEn && (r_remain != c_lenZero) && (w_level < 3'd2)) begin
          w_issue = 1'b1;
          if (r_remain == c_lenOne) begin
            w_stateNext = DRAIN;
          end
        end
      end
      DRAIN: begin
        // No read is in flight and the buffer empties on this edge.
        if (AClkHEn && !r_inFlight && (w_level == 3'd0)) begin
          w_finish    = 1'b1;
          w_stateNext = IDLE;
        end
      end
      default: begin
        w_stateNext = IDLE;
      end
    endcase

    w_issueLast = w_issue && (w_curRemain == c_lenOne);
  end

  // A capture lands in slot 0 whenever slot 0 is free after this edge's pop.
  assign w_wrSlot0 = (r_occ == 2'd0) || ((r_occ == 2'd1) && w_pop);

  // --------------------------------------------------------------------------
  // Address / count tracking, output buffer and completion pulse
  // --------------------------------------------------------------------------
  always_ff @(posedge AClkH or negedge AResetHN) begin
    if (!AResetHN) begin
      r_nextAddr     <= '0;
      r_holdAddr     <= '0;
      r_remain       <= '0;
      r_inFlight     <= 1'b0;
      r_inFlightLast <= 1'b0;
      r_occ          <= 2'd0;
      r_data0        <= '0;
      r_data1        <= '0;
      r_last0        <= 1'b0;
      r_last1        <= 1'b0;
      r_done         <= 1'b0;
    end else begin
      if (w_issue) begin
        r_nextAddr <= w_issueAddr + c_addrOne;
        r_remain   <= w_curRemain - c_lenOne;
        r_holdAddr <= w_issueAddr;
      end

      // Capture happens on the edge after issue even when the enable is low,
      // because the RAM only presents the word for that one cycle.
      r_inFlight     <= w_issue;
      r_inFlightLast <= w_issueLast;

      if (w_pop) begin
        r_data0 <= r_data1;
        r_last0 <= r_last1;
      end
      if (r_inFlight) begin
        if (w_wrSlot0) begin
          r_data0 <= ARamMiso;
          r_last0 <= r_inFlightLast;
        end else begin
          r_data1 <= ARamMiso;
          r_last1 <= r_inFlightLast;
        end
      end
      r_occ <= r_occ + {1'b0, r_inFlight} - {1'b0, w_pop};

      // The pulse is held across disabled cycles so an enable-qualified
      // observer always sees it for exactly one enabled cycle.
      r_done <= w_finish || w_zeroAccept || (r_done && !AClkHEn);
    end
  end

  assign ARamRdEn   = w_issue;
  assign ARamAddr   = w_issue ? w_issueAddr : r_holdAddr;
  assign ARamWrEn   = 1'b0;
  assign AStrmData  = r_data0;
  assign AStrmValid = (r_occ != 2'd0);
  assign AStrmLast  = (r_occ != 2'd0) && r_last0;
  assign ABusy      = (r_state != IDLE);
  assign ADone      = r_done;

endmodule
`default_nettype wire

// File: tb/tb_ram_burst_reader.sv
`default_nettype none
// ============================================================================
// Module   : tb_ram_burst_reader
// Purpose  : Self-checking bench for ram_burst_reader. A RAM model answers
//            reads; a burst-level model predicts addresses, words, flags and
//            handshakes; directed bursts add literal expectations.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ram_burst_reader;

  logic         AClkH = 1'b0;
  logic         AResetHN;
  logic         AClkHEn;
  logic [12:0]  ACmdAddr;
  logic [7:0]   ACmdLen;
  logic         ACmdValid;
  logic         ACmdReady;
  logic [12:0]  ARamAddr;
  logic         ARamRdEn;
  logic         ARamWrEn;
  logic [127:0] ARamMiso = '0;
  logic [127:0] AStrmData;
  logic         AStrmValid;
  logic         AStrmLast;
  logic         AStrmReady;
  logic         ABusy;
  logic         ADone;

  ram_burst_reader #(.CAddrLen(13), .CDataLen(128), .CLenLen(8)) dut (
    .AClkH(AClkH), .AResetHN(AResetHN), .AClkHEn(AClkHEn),
    .ACmdAddr(ACmdAddr), .ACmdLen(ACmdLen), .ACmdValid(ACmdValid),
    .ACmdReady(ACmdReady), .ARamAddr(ARamAddr), .ARamRdEn(ARamRdEn),
    .ARamWrEn(ARamWrEn), .ARamMiso(ARamMiso), .AStrmData(AStrmData),
    .AStrmValid(AStrmValid), .AStrmLast(AStrmLast), .AStrmReady(AStrmReady),
    .ABusy(ABusy), .ADone(ADone)
  );

  always #5 AClkH = ~AClkH;

  logic [127:0] ram [0:8191];
  always @(posedge AClkH) ARamMiso <= ARamRdEn ? ram[ARamAddr] : '0;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always @(posedge AClkH) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- burst-level model ----------------
  logic [127:0] expData[$];
  bit           expLast[$];
  logic [12:0]  expAddr[$];
  logic [127:0] gotData[$];
  logic [12:0]  gotAddr[$];
  int           avail, s1, s2, remExp, doneCnt, acceptCyc, firstLat;
  bit           busyExp, doneExp, prevHold, prevDone, waitFirst;
  logic [12:0]  lastAddr;
  logic [127:0] prevData;
  bit           prevLast;

  initial begin
    avail = 0; s1 = 0; s2 = 0; remExp = 0; doneCnt = 0; acceptCyc = 0; firstLat = -1;
    busyExp = 0; doneExp = 0; prevHold = 0; prevDone = 0; waitFirst = 0;
    lastAddr = '0; prevData = '0; prevLast = 0;
  end

  always @(negedge AClkH) begin : compare
    bit en, popM, acc, expRd, lastPop;
    if (!AResetHN) begin
      chk("reset_ctrl", {ARamAddr, ARamRdEn, ARamWrEn, AStrmValid, AStrmLast, ABusy, ADone, ACmdReady}, '0);
      chk("reset_data", AStrmData, '0);
      expData.delete(); expLast.delete(); expAddr.delete();
      avail = 0; s1 = 0; s2 = 0; remExp = 0;
      busyExp = 0; doneExp = 0; prevHold = 0; prevDone = 0; waitFirst = 0;
      lastAddr = '0;
    end else begin
      en = AClkHEn;
      lastPop = 0;
      // a read issued two samples ago is now in the buffer
      avail = avail + s2; s2 = s1; s1 = 0;
      chk("wr_en", ARamWrEn, 0);
      chk("busy", ABusy, busyExp);
      chk("done", ADone, doneExp);
      chk("cmd_ready", ACmdReady, en && !busyExp && !doneExp);
      chk("strm_valid", AStrmValid, avail > 0);
      if (prevHold) begin
        chk("hold_data", AStrmData, prevData);
        chk("hold_last", AStrmLast, prevLast);
      end
      if (waitFirst && AStrmValid) begin
        firstLat = cyc - acceptCyc;
        waitFirst = 0;
      end
      popM = (avail > 0) && AStrmReady && en;
      acc  = ACmdValid && ACmdReady && en;
      if (acc) begin
        for (int k = 0; k < int'(ACmdLen); k++) begin
          logic [12:0] a;
          a = ACmdAddr + 13'(k);
          expAddr.push_back(a);
          expData.push_back(ram[a]);
          expLast.push_back(k == int'(ACmdLen) - 1);
        end
        remExp = int'(ACmdLen);
        acceptCyc = cyc;
        waitFirst = (ACmdLen != 0);
      end
      expRd = en && (remExp > 0) && ((avail - int'(popM) + s2) < 2);
      chk("rd_en", ARamRdEn, expRd);
      if (ARamRdEn) begin
        if (expAddr.size() > 0) chk("rd_addr", ARamAddr, expAddr.pop_front());
        else chk("rd_unexpected", ARamRdEn, 0);
        gotAddr.push_back(ARamAddr);
        lastAddr = ARamAddr;
        s1 = 1;
        remExp--;
      end else begin
        chk("addr_hold", ARamAddr, lastAddr);
      end
      if (AStrmValid) begin
        if (expData.size() > 0) begin
          chk("strm_data", AStrmData, expData[0]);
          chk("strm_last", AStrmLast, expLast[0]);
        end else begin
          chk("strm_unexpected", AStrmValid, 0);
        end
      end
      if (popM && expData.size() > 0) begin
        gotData.push_back(AStrmData);
        lastPop = expLast[0];
        void'(expData.pop_front());
        void'(expLast.pop_front());
        avail--;
      end
      if (ADone && !prevDone) doneCnt++;
      prevDone = ADone;
      doneExp  = (doneExp && !en) || lastPop || (acc && ACmdLen == 0);
      if (acc && ACmdLen != 0) busyExp = 1;
      if (lastPop) busyExp = 0;
      prevHold = AStrmValid && !popM;
      prevData = AStrmData;
      prevLast = AStrmLast;
    end
  end

  // ---------------- stimulus ----------------
  task automatic runBurst(input logic [12:0] addr, input logic [7:0] len,
                          input logic [31:0] rdyMask, input logic [31:0] enMask);
    int startDone, off, guard;
    bit accepted;
    gotData.delete(); gotAddr.delete();
    startDone = doneCnt;
    firstLat = -1;
    @(posedge AClkH); #1;
    ACmdAddr = addr; ACmdLen = len; ACmdValid = 1'b1; AClkHEn = 1'b1; AStrmReady = rdyMask[0];
    guard = 0;
    accepted = 0;
    do begin
      @(negedge AClkH);
      accepted = ACmdReady;
      if (!accepted) begin @(posedge AClkH); #1; guard++; end
    end while (!accepted && guard < 10);
    off = 1;
    while (doneCnt == startDone && off < 80) begin
      @(posedge AClkH); #1;
      ACmdValid  = 1'b0;
      AStrmReady = (off < 32) ? rdyMask[off] : 1'b1;
      AClkHEn    = (off < 32) ? enMask[off] : 1'b1;
      @(negedge AClkH);
      off++;
    end
    chk("burst_completes", doneCnt - startDone, 1);
    @(posedge AClkH); #1;
    ACmdValid = 1'b0; AClkHEn = 1'b1; AStrmReady = 1'b1;
  endtask

  initial begin
    for (int i = 0; i < 8192; i++) ram[i] = 128'(i);
    AResetHN = 1'b0; AClkHEn = 1'b1; ACmdAddr = '0; ACmdLen = '0;
    ACmdValid = 1'b0; AStrmReady = 1'b1;
    repeat (2) @(posedge AClkH);
    #1 chk("ready_in_reset", ACmdReady, 0);
    @(posedge AClkH); #2 AResetHN = 1'b1;
    #1 chk("ready_after_release", ACmdReady, 1);

    // consumer always ready
    runBurst(13'h0010, 8'd4, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    chk("b1_nreads", gotAddr.size(), 4);
    chk("b1_nwords", gotData.size(), 4);
    for (int i = 0; i < 4 && i < gotData.size(); i++) begin
      chk("b1_addr", gotAddr[i], 13'h0010 + 13'(i));
      chk("b1_word", gotData[i], 128'h10 + 128'(i));
    end
    chk("b1_latency", firstLat, 2);

    // back-pressure on cycles 3..7 after accept
    runBurst(13'h0010, 8'd4, 32'hFFFF_FF07, 32'hFFFF_FFFF);
    chk("bp_nwords", gotData.size(), 4);
    for (int i = 0; i < 4 && i < gotData.size(); i++) chk("bp_word", gotData[i], 128'h10 + 128'(i));

    // address wrap
    runBurst(13'h1FFE, 8'd4, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    chk("wrap_nreads", gotAddr.size(), 4);
    if (gotAddr.size() == 4) begin
      chk("wrap_a0", gotAddr[0], 13'h1FFE);
      chk("wrap_a1", gotAddr[1], 13'h1FFF);
      chk("wrap_a2", gotAddr[2], 13'h0000);
      chk("wrap_a3", gotAddr[3], 13'h0001);
    end

    // zero-length command
    runBurst(13'h0200, 8'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    chk("zero_nreads", gotAddr.size(), 0);
    chk("zero_nwords", gotData.size(), 0);

    // clock-enable gating 1,0,1,0 during a 3-word burst
    runBurst(13'h0020, 8'd3, 32'hFFFF_FFFF, 32'hFFFF_FF55);
    chk("ce_nwords", gotData.size(), 3);
    for (int i = 0; i < 3 && i < gotData.size(); i++) chk("ce_word", gotData[i], 128'h20 + 128'(i));

    // reset with two words buffered
    gotData.delete(); gotAddr.delete();
    @(posedge AClkH); #1;
    ACmdAddr = 13'h0040; ACmdLen = 8'd8; ACmdValid = 1'b1; AClkHEn = 1'b1; AStrmReady = 1'b0;
    @(posedge AClkH); #1;
    ACmdValid = 1'b0;
    repeat (3) @(posedge AClkH);
    #2;
    chk("pre_reset_busy", ABusy, 1);
    chk("pre_reset_valid", AStrmValid, 1);
    AResetHN = 1'b0;
    #1;
    chk("reset_now_ctrl", {ARamAddr, ARamRdEn, ARamWrEn, AStrmValid, AStrmLast, ABusy, ADone, ACmdReady}, '0);
    chk("reset_now_data", AStrmData, '0);
    @(posedge AClkH); #2 AResetHN = 1'b1;
    AStrmReady = 1'b1;
    runBurst(13'h0100, 8'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    chk("post_reset_nwords", gotData.size(), 1);
    if (gotData.size() > 0) chk("post_reset_word", gotData[0], 128'h100);

    repeat (3) @(posedge AClkH);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire

// File: doc/ram_burst_reader.md
RAM_BURST_READER -- requirements
Module: ram_burst_reader

Interface
REQ-001 Parameters SHALL be CAddrLen = 13 (RAM word address width), CDataLen = 128 (RAM word width) and CLenLen = 8 (burst length field width).
REQ-002 The block SHALL have one clock and an asynchronous, active-low reset, with ports named AClkH and AResetHN; the polarity and synchronicity are fixed.
REQ-003 Ports, one per line:
- AClkH  in  1  clock, rising edge.
- AResetHN  in  1  asynchronous reset, active low.
- AClkHEn  in  1  clock enable.
- ACmdAddr  in  CAddrLen  burst start word address.
- ACmdLen  in  CLenLen  burst length in words; 0 = no-op.
- ACmdValid  in  1  command offered.
- ACmdReady  out  1  command accepted when high together with ACmdValid and AClkHEn.
- ARamAddr  out  CAddrLen  address to the single-port RAM.
- ARamRdEn  out  1  read strobe to the RAM; data returns on ARamMiso one clock later.
- ARamWrEn  out  1  tied 0.
- ARamMiso  in  CDataLen  RAM read data; all zeros unless a read was issued in the previous cycle.
- AStrmData  out  CDataLen  output word.
- AStrmValid  out  1  output word valid.
- AStrmLast  out  1  marks the final word of a burst.
- AStrmReady  in  1  consumer accepts the word.
- ABusy  out  1  burst in progress.
- ADone  out  1  one-cycle pulse at burst completion.

Function
REQ-004 The state machine SHALL have three states, IDLE, RUN and DRAIN, and SHALL advance only on edges where AClkHEn = 1, except for the capture rule in REQ-010.
REQ-005 ACmdReady SHALL be 1 only in IDLE; ABusy SHALL be 1 in RUN and DRAIN.
REQ-006 In IDLE, a command is accepted on ACmdValid & ACmdReady & AClkHEn.
- ACmdLen = 0: the block stays in IDLE and pulses ADone in the next cycle.
- ACmdLen > 0: the block loads the address counter and the remaining-count counter and enters RUN.
REQ-007 In RUN, a read SHALL be issued (ARamRdEn = 1, ARamAddr = current address) on a cycle when all of the following hold:
- AClkHEn = 1;
- remaining > 0;
- (buffer occupancy - pop this cycle + in-flight reads) < 2.
REQ-008 Each issued read SHALL:
- decrement remaining;
- increment the address modulo 2^CAddrLen, so 0x1FFF wraps to 0x0000.
REQ-009 When the last read is issued, the state SHALL become DRAIN.
REQ-010 Capture and hold rules:
- Read data SHALL be captured from ARamMiso into the 2-entry output buffer on the edge immediately following the issue, regardless of AClkHEn.
- At most one read SHALL be in flight at any time.
- When no read is being issued, ARamAddr SHALL hold its last value.
REQ-011 The output buffer SHALL be a 2-entry FIFO.
- AStrmValid = occupancy > 0.
- AStrmData = head entry.
- A pop occurs on AStrmValid & AStrmReady & AClkHEn.
- A simultaneous capture and pop SHALL keep occupancy unchanged and preserve word order.
REQ-012 AStrmLast SHALL be 1 exactly when the head entry is the final word of the burst.
REQ-013 Sustained throughput SHALL be one word per cycle while AStrmReady = 1 and AClkHEn = 1. First-word latency from command acceptance to AStrmValid SHALL be 2 cycles.
REQ-014 Under back-pressure, AStrmData and AStrmLast SHALL remain stable while AStrmValid = 1 and no pop occurs; no word SHALL be lost or duplicated.
REQ-015 In DRAIN, once occupancy = 0 and no read is in flight, the block SHALL:
- pulse ADone for one cycle;
- return to IDLE.
The earliest a new command can be accepted is the cycle after the ADone pulse.
REQ-016 While AClkHEn = 0:
- ARamRdEn and ACmdReady SHALL be 0;
- no pop SHALL occur;
- all outputs SHALL hold.

Reset
REQ-017 Assertion of AResetHN = 0 SHALL immediately force:
- state = IDLE;
- ARamAddr = 0, ARamRdEn = 0, ARamWrEn = 0;
- AStrmData = 0, AStrmValid = 0, AStrmLast = 0;
- ABusy = 0, ADone = 0;
- ACmdReady = 0 during reset, 1 after release.
REQ-018 A reset during RUN or DRAIN SHALL discard buffered and in-flight data. No ADone SHALL be produced for the aborted burst.

Verification
REQ-019 Burst with consumer always ready:
- Stimulus: ACmdAddr = 0x0010, ACmdLen = 4, RAM preloaded with word[i] = i, AStrmReady = 1.
- Response: ARamRdEn high for 4 consecutive cycles on addresses 0x10..0x13; AStrmData = 0x10..0x13 on 4 consecutive cycles; AStrmLast on 0x13; ADone 1 cycle after the last pop.
REQ-020 Back-pressure:
- Stimulus: same burst with AStrmReady low for cycles 3..7 after accept.
- Response: occupancy never exceeds 2; no read is issued while the buffer is full plus in-flight; all 4 words arrive in order.
REQ-021 Wrap-around:
- Stimulus: ACmdAddr = 0x1FFE, ACmdLen = 4.
- Response: ARamAddr sequence 0x1FFE, 0x1FFF, 0x0000, 0x0001.
REQ-022 Zero-length command:
- Stimulus: ACmdLen = 0.
- Response: no ARamRdEn, AStrmValid stays 0, ADone pulses once, ABusy stays 0.
REQ-023 Reset mid-operation:
- Stimulus: AResetHN pulsed low mid-burst with 2 words buffered.
- Response: outputs are zero immediately; after release, a new burst with ACmdLen = 1 returns only its own word.
REQ-024 Clock-enable gating:
- Stimulus: AClkHEn toggled 1,0,1,0 during a 3-word burst.
- Response: reads are issued only on enabled cycles; words are captured correctly; output order and AStrmLast are correct.
